// File: rtl/decode_stage.sv
// decode_stage: single-cycle RV32I decode stage with load-use hazard detection.
// Decoded fields, immediate, PC, valid and illegal flag are registered; the
// stall and flush requests to fetch are combinational.
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to flag opcodes outside the
// RV32I base set on ds_o_illegal; otherwise ds_o_illegal is always 0.
module decode_stage #(
   parameter int IWIDTH   = 32,
   parameter int PC_WIDTH = 32,
   parameter int DWIDTH   = 32
) (
   input  logic                ds_clk,
   input  logic                ds_rst,
   input  logic [IWIDTH-1:0]   ds_i_instr,
   input  logic [PC_WIDTH-1:0] ds_i_pc,
   input  logic                ds_i_ce,
   input  logic                ds_i_stall,
   input  logic                ds_i_flush,
   output logic [6:0]          ds_o_opcode,
   output logic [2:0]          ds_o_funct3,
   output logic [6:0]          ds_o_funct7,
   output logic [4:0]          ds_o_rs1_addr,
   output logic [4:0]          ds_o_rs2_addr,
   output logic [4:0]          ds_o_rd_addr,
   output logic [DWIDTH-1:0]   ds_o_imm,
   output logic [PC_WIDTH-1:0] ds_o_pc,
   output logic                ds_o_ce,
   output logic                ds_o_stall,
   output logic                ds_o_flush,
   output logic                ds_o_illegal
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // 32-bit immediate selected by opcode; sign extension to DWIDTH happens at the use site
   function automatic logic [31:0] imm_gen(input logic [31:0] ins);
      logic [31:0] r;
      r = '0;
      case (ins[6:0])
         OP_LOAD, OP_IMM, OP_JALR: r = {{20{ins[31]}}, ins[31:20]};
         OP_STORE:                 r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         OP_BRANCH:                r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         r = {ins[31:12], 12'b0};
         OP_JAL:                   r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:                  r = '0;
      endcase
      return r;
   endfunction

`ifdef DECODE_ILLEGAL_CHECK_EN
   // Base-set membership; every base opcode ends in 2'b11, so a bad
   // compressed-quadrant field is rejected by the same lookup.
   function automatic logic is_legal(input logic [6:0] op);
      logic r;
      case (op)
         OP_LOAD, OP_MISC, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
         OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: r = 1'b1;
         default:                                       r = 1'b0;
      endcase
      return r;
   endfunction
`endif

   logic [31:0]         instr;
   logic [6:0]          in_opcode;
   logic [4:0]          in_rs1;
   logic [4:0]          in_rs2;
   logic                in_uses_rs2;
   logic                hazard;
   logic                illegal_in;

   logic [6:0]          opcode_q, opcode_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [6:0]          funct7_q, funct7_d;
   logic [4:0]          rs1_q, rs1_d;
   logic [4:0]          rs2_q, rs2_d;
   logic [4:0]          rd_q, rd_d;
   logic [DWIDTH-1:0]   imm_q, imm_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                ce_q, ce_d;
   logic                illegal_q, illegal_d;

   assign instr     = ds_i_instr[31:0];
   assign in_opcode = instr[6:0];
   assign in_rs1    = instr[19:15];
   assign in_rs2    = instr[24:20];

`ifdef DECODE_ILLEGAL_CHECK_EN
   assign illegal_in = ~is_legal(in_opcode);
`else
   assign illegal_in = 1'b0;
`endif

   // Load-use detection: a valid load in the output register writes a source of the incoming instruction
   always_comb begin
      in_uses_rs2 = (in_opcode == OP_REG) || (in_opcode == OP_STORE) || (in_opcode == OP_BRANCH);
      hazard      = ce_q && (opcode_q == OP_LOAD) && (rd_q != 5'd0) && ds_i_ce &&
                    ((in_rs1 == rd_q) || (in_uses_rs2 && (in_rs2 == rd_q)));
   end

   assign ds_o_stall = ds_i_stall | hazard;
   assign ds_o_flush = ds_i_flush;

   // Next-state selection: flush beats stall beats hazard beats normal capture
   always_comb begin
      opcode_d  = opcode_q;
      funct3_d  = funct3_q;
      funct7_d  = funct7_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      imm_d     = imm_q;
      pc_d      = pc_q;
      ce_d      = ce_q;
      illegal_d = illegal_q;
      if (ds_i_flush) begin
         ce_d      = 1'b0;
         illegal_d = 1'b0;
      end else if (ds_i_stall) begin
         ce_d      = ce_q;
      end else if (hazard) begin
         ce_d      = 1'b0;
      end else begin
         opcode_d  = in_opcode;
         funct3_d  = instr[14:12];
         funct7_d  = instr[31:25];
         rs1_d     = in_rs1;
         rs2_d     = in_rs2;
         rd_d      = instr[11:7];
         imm_d     = DWIDTH'($signed(imm_gen(instr)));
         pc_d      = ds_i_pc;
         ce_d      = ds_i_ce;
         illegal_d = ds_i_ce & illegal_in;
      end
   end

   // Output register bank with synchronous clear
   always_ff @(posedge ds_clk) begin
      if (ds_rst) begin
         opcode_q  <= '0;
         funct3_q  <= '0;
         funct7_q  <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         pc_q      <= '0;
         ce_q      <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         opcode_q  <= opcode_d;
         funct3_q  <= funct3_d;
         funct7_q  <= funct7_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         imm_q     <= imm_d;
         pc_q      <= pc_d;
         ce_q      <= ce_d;
         illegal_q <= illegal_d;
      end
   end

   assign ds_o_opcode   = opcode_q;
   assign ds_o_funct3   = funct3_q;
   assign ds_o_funct7   = funct7_q;
   assign ds_o_rs1_addr = rs1_q;
   assign ds_o_rs2_addr = rs2_q;
   assign ds_o_rd_addr  = rd_q;
   assign ds_o_imm      = imm_q;
   assign ds_o_pc       = pc_q;
   assign ds_o_ce       = ce_q;
   assign ds_o_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: reset, field/immediate decode,
// load-use bubble, stall/flush priority, illegal flag and reset mid-stall.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        ce;
   logic        stall;
   logic        flush;
   logic [6:0]  o_opcode;
   logic [2:0]  o_funct3;
   logic [6:0]  o_funct7;
   logic [4:0]  o_rs1;
   logic [4:0]  o_rs2;
   logic [4:0]  o_rd;
   logic [31:0] o_imm;
   logic [31:0] o_pc;
   logic        o_ce;
   logic        o_stall;
   logic        o_flush;
   logic        o_illegal;

   int errors = 0;
   int checks = 0;

`ifdef DECODE_ILLEGAL_CHECK_EN
   localparam logic EXP_ILLEGAL = 1'b1;
`else
   localparam logic EXP_ILLEGAL = 1'b0;
`endif

   decode_stage #(.IWIDTH(32), .PC_WIDTH(32), .DWIDTH(32)) dut (
      .ds_clk        (clk),
      .ds_rst        (rst),
      .ds_i_instr    (instr),
      .ds_i_pc       (pc),
      .ds_i_ce       (ce),
      .ds_i_stall    (stall),
      .ds_i_flush    (flush),
      .ds_o_opcode   (o_opcode),
      .ds_o_funct3   (o_funct3),
      .ds_o_funct7   (o_funct7),
      .ds_o_rs1_addr (o_rs1),
      .ds_o_rs2_addr (o_rs2),
      .ds_o_rd_addr  (o_rd),
      .ds_o_imm      (o_imm),
      .ds_o_pc       (o_pc),
      .ds_o_ce       (o_ce),
      .ds_o_stall    (o_stall),
      .ds_o_flush    (o_flush),
      .ds_o_illegal  (o_illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; instr = 32'h0050_0093; pc = 32'h4; ce = 1'b1; stall = 1'b0; flush = 1'b0;

      // Reset held two cycles with valid input
      tick(); tick();
      chk("rst_ce",      32'(o_ce),      32'h0);
      chk("rst_opcode",  32'(o_opcode),  32'h0);
      chk("rst_rd",      32'(o_rd),      32'h0);
      chk("rst_imm",     o_imm,          32'h0);
      chk("rst_pc",      o_pc,           32'h0);
      chk("rst_illegal", 32'(o_illegal), 32'h0);
      chk("rst_stall",   32'(o_stall),   32'h0);

      // addi x1, x0, 5 captured on first edge after release
      rst = 1'b0;
      tick();
      chk("addi_ce",     32'(o_ce),      32'h1);
      chk("addi_opcode", 32'(o_opcode),  32'h13);
      chk("addi_rd",     32'(o_rd),      32'h1);
      chk("addi_rs1",    32'(o_rs1),     32'h0);
      chk("addi_imm",    o_imm,          32'h5);
      chk("addi_pc",     o_pc,           32'h4);

      // S-type: imm = {1111111, 11100} = -4
      instr = 32'hFE11_2E23; pc = 32'h8;
      tick();
      chk("sw_opcode", 32'(o_opcode), 32'h23);
      chk("sw_imm",    o_imm,         32'hFFFF_FFFC);
      chk("sw_rs1",    32'(o_rs1),    32'h2);
      chk("sw_rs2",    32'(o_rs2),    32'h1);
      chk("sw_funct3", 32'(o_funct3), 32'h2);

      // B-type: imm[12]=1 imm[11]=instr[7]=1 imm[10:5]=111111 imm[4:1]=1110 -> -4
      instr = 32'hFE00_0EE3; pc = 32'hC;
      tick();
      chk("beq_imm",    o_imm,         32'hFFFF_FFFC);
      chk("beq_funct7", 32'(o_funct7), 32'h7F);

      // U-type
      instr = 32'h1234_50B7; pc = 32'h10;
      tick();
      chk("lui_imm", o_imm,      32'h1234_5000);
      chk("lui_rd",  32'(o_rd),  32'h1);
      chk("lui_pc",  o_pc,       32'h10);

      // J-type, zero offset
      instr = 32'h0000_006F; pc = 32'h14;
      tick();
      chk("jal_imm",    o_imm,         32'h0);
      chk("jal_opcode", 32'(o_opcode), 32'h6F);

      // Load-use: lw x1 then add x2,x1,x1
      instr = 32'h0000_2083; pc = 32'h18;
      tick();
      chk("lw_ce", 32'(o_ce), 32'h1);
      chk("lw_rd", 32'(o_rd), 32'h1);
      instr = 32'h0010_8133; pc = 32'h1C;
      #1;
      chk("lu_stall_req", 32'(o_stall), 32'h1);
      tick();
      chk("lu_bubble_ce",  32'(o_ce),     32'h0);
      chk("lu_bubble_op",  32'(o_opcode), 32'h03);
      chk("lu_bubble_pc",  o_pc,          32'h18);
      chk("lu_stall_clr",  32'(o_stall),  32'h0);
      tick();
      chk("add_ce",     32'(o_ce),     32'h1);
      chk("add_opcode", 32'(o_opcode), 32'h33);
      chk("add_rd",     32'(o_rd),     32'h2);
      chk("add_pc",     o_pc,          32'h1C);

      // Load to x0 never creates a hazard
      instr = 32'h0000_2003; pc = 32'h20;
      tick();
      instr = 32'h0000_0033; pc = 32'h24;
      #1;
      chk("x0_no_stall", 32'(o_stall), 32'h0);
      tick();
      chk("x0_next_ce", 32'(o_ce),     32'h1);
      chk("x0_next_pc", o_pc,          32'h24);
      chk("x0_rd",      32'(o_rd),     32'h0);

      // Downstream stall for three cycles freezes the outputs
      instr = 32'h1234_50B7; pc = 32'h28; stall = 1'b1;
      #1;
      chk("stall_req", 32'(o_stall), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ce",     32'(o_ce),     32'h1);
         chk("stall_opcode", 32'(o_opcode), 32'h33);
         chk("stall_pc",     o_pc,          32'h24);
      end

      // Flush overrides stall
      flush = 1'b1;
      #1;
      chk("flush_same_cycle", 32'(o_flush), 32'h1);
      tick();
      chk("flush_ce",      32'(o_ce),      32'h0);
      chk("flush_illegal", 32'(o_illegal), 32'h0);
      flush = 1'b0; stall = 1'b0;
      #1;
      chk("flush_drop", 32'(o_flush), 32'h0);

      // All-ones instruction: opcode 1111111 is outside the base set
      instr = 32'hFFFF_FFFF; pc = 32'h2C;
      tick();
      chk("ill_ce",      32'(o_ce),      32'h1);
      chk("ill_opcode",  32'(o_opcode),  32'h7F);
      chk("ill_flag",    32'(o_illegal), 32'(EXP_ILLEGAL));

      // Idle input gives no valid output
      ce = 1'b0; instr = 32'h0050_0093; pc = 32'h30;
      tick();
      chk("idle_ce",      32'(o_ce),      32'h0);
      chk("idle_illegal", 32'(o_illegal), 32'h0);

      // Reset while stalled and during a pending hazard clears everything
      ce = 1'b1; instr = 32'h0000_2083; pc = 32'h34;
      tick();
      instr = 32'h0010_8133; pc = 32'h38; stall = 1'b1; rst = 1'b1;
      tick();
      chk("rst_mid_ce",     32'(o_ce),     32'h0);
      chk("rst_mid_opcode", 32'(o_opcode), 32'h0);
      chk("rst_mid_pc",     o_pc,          32'h0);
      chk("rst_mid_hazard", 32'(o_stall),  32'h1);
      stall = 1'b0;
      #1;
      chk("rst_mid_nohaz", 32'(o_stall), 32'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_ce", 32'(o_ce), 32'h1);
      chk("post_rst_pc", o_pc,      32'h38);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
